// File: rtl/jtag_tap_master.sv
// jtag_tap_master: JTAG host engine. Takes valid/ready commands (TAP reset,
// Run-Test/Idle dwell, IR scan, DR scan), drives TCK/TMS/TDI, and returns
// the TDO bits captured during Shift-xR.
// Optional: define JTAG_TAP_MASTER_TRST_EN to add the TRST_N output.
module jtag_tap_master #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 7,
  parameter int DIV    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO
`ifdef JTAG_TAP_MASTER_TRST_EN
  ,
  output logic              TRST_N
`endif
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DATA_W);
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);
  localparam logic [LEN_W-1:0] TWO      = LEN_W'(2);

  typedef enum logic [2:0] {
    IDLE, RESET5, SEL, CAPTURE, SHIFT, EXIT_UPD, DWELL, DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_RESET, OP_IDLE, OP_IR, OP_DR
  } op_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [LEN_W-1:0]  rem, rem_nx;      // rises left in the current state
  logic [LEN_W-1:0]  len, len_nx;      // saturated scan length
  logic [LEN_W-1:0]  len_sat;
  logic [DATA_W-1:0] sdata, sdata_nx;  // TDI bits still to send, LSB next
  logic [DATA_W-1:0] cap, cap_nx;      // TDO samples enter at the MSB
  logic              tck_nx, tms_nx, tdi_nx;
  logic              rsp_valid_nx;
  logic [DATA_W-1:0] rsp_data_nx;
  logic              accept;
  logic              tick;

  assign cmd_ready = (state == IDLE) && !rsp_valid;
  assign accept    = cmd_valid && cmd_ready;
  assign len_sat   = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
  assign tick      = (cnt == CNT_LAST);

  // State and pin registers; reset aborts any command in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      len       <= '0;
      sdata     <= '0;
      cap       <= '0;
      TCK       <= 1'b0;
      TMS       <= 1'b1;
      TDI       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rem       <= rem_nx;
      len       <= len_nx;
      sdata     <= sdata_nx;
      cap       <= cap_nx;
      TCK       <= tck_nx;
      TMS       <= tms_nx;
      TDI       <= tdi_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_data  <= rsp_data_nx;
    end
  end

  // Next state: TCK rises sample TDO, TCK falls advance the sequence and
  // set up TMS/TDI for the following rise
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    rem_nx       = rem;
    len_nx       = len;
    sdata_nx     = sdata;
    cap_nx       = cap;
    tck_nx       = TCK;
    tms_nx       = TMS;
    tdi_nx       = TDI;
    rsp_valid_nx = rsp_valid;
    rsp_data_nx  = rsp_data;

    if (rsp_valid && rsp_ready) rsp_valid_nx = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nx   = '0;
          tck_nx   = 1'b0;
          tdi_nx   = 1'b0;
          len_nx   = len_sat;
          sdata_nx = cmd_data;
          cap_nx   = '0;
          case (op_t'(cmd_op))
            OP_RESET: begin
              state_nx = RESET5;
              rem_nx   = LEN_W'(5);
              tms_nx   = 1'b1;
            end
            OP_IDLE: begin
              if (len_sat == '0) begin
                state_nx = DONE;
              end else begin
                state_nx = DWELL;
                rem_nx   = len_sat;
                tms_nx   = 1'b0;
              end
            end
            default: begin
              if (len_sat == '0) begin
                state_nx = DONE;
              end else begin
                state_nx = SEL;
                rem_nx   = (op_t'(cmd_op) == OP_IR) ? TWO : ONE;
                tms_nx   = 1'b1;
              end
            end
          endcase
        end
      end
      DONE: begin
        // Captured bits sit at the top of cap; align bit 0 to the first sample
        state_nx     = IDLE;
        rsp_valid_nx = 1'b1;
        rsp_data_nx  = cap >> (LEN_MAX - len);
      end
      default: begin
        if (!tick) begin
          cnt_nx = cnt + CW'(1);
        end else begin
          cnt_nx = '0;
          tck_nx = ~TCK;
          if (!TCK) begin
            if (state == SHIFT) cap_nx = {TDO, cap[DATA_W-1:1]};
          end else begin
            rem_nx = rem - ONE;
            case (state)
              RESET5: begin
                if (rem == ONE) begin
                  state_nx = DWELL;
                  rem_nx   = ONE;
                  tms_nx   = 1'b0;
                end
              end
              SEL: begin
                if (rem == ONE) begin
                  state_nx = CAPTURE;
                  rem_nx   = TWO;
                  tms_nx   = 1'b0;
                end
              end
              CAPTURE: begin
                if (rem == ONE) begin
                  state_nx = SHIFT;
                  rem_nx   = len;
                  tms_nx   = (len == ONE);
                  tdi_nx   = sdata[0];
                end
              end
              SHIFT: begin
                sdata_nx = sdata >> 1;
                if (rem == ONE) begin
                  state_nx = EXIT_UPD;
                  rem_nx   = ONE;
                  tms_nx   = 1'b1;
                  tdi_nx   = 1'b0;
                end else begin
                  tms_nx = (rem == TWO);
                  tdi_nx = sdata[1];
                end
              end
              EXIT_UPD: begin
                state_nx = DWELL;
                rem_nx   = ONE;
                tms_nx   = 1'b0;
              end
              default: begin
                if (rem == ONE) state_nx = DONE;
              end
            endcase
          end
        end
      end
    endcase
  end

`ifdef JTAG_TAP_MASTER_TRST_EN
  logic rst_seq, rst_seq_nx;

  // TRST_N is held low from TAP_RESET accept until the fall that ends it
  always_comb begin
    rst_seq_nx = rst_seq;
    if (accept && (op_t'(cmd_op) == OP_RESET)) rst_seq_nx = 1'b1;
    else if (state_nx == DONE)                 rst_seq_nx = 1'b0;
  end

  // TRST_N register: low in reset, high one clk after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_seq <= 1'b0;
      TRST_N  <= 1'b0;
    end else begin
      rst_seq <= rst_seq_nx;
      TRST_N  <= ~rst_seq_nx;
    end
  end
`endif

endmodule

// File: doc/jtag_tap_master.md
Name: jtag_tap_master

Overview:
- JTAG host engine that drives the TAP pins of the boundary-scan Top from a simple command interface.
- Generates TCK, TMS and TDI, and samples TDO, to perform TAP reset, IR scans, DR scans and Run-Test/Idle dwell.
- Sits between an on-chip or bench controller (valid/ready commands) and the TAP of the device under test.
- Returns the TDO bits captured during each scan.

Parameters:
- DATA_W, 64: maximum scan length in bits; width of cmd_data and rsp_data.
- LEN_W, 7: width of cmd_len; must satisfy 2^LEN_W > DATA_W.
- DIV, 3: TCK half-period in clk cycles (TCK period = 2*DIV clk cycles); minimum 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  engine accepts a command this cycle.
- cmd_op  input  2  0=TAP_RESET, 1=IDLE_CYCLES, 2=IR_SCAN, 3=DR_SCAN.
- cmd_len  input  LEN_W  bit count (scans) or TCK count (IDLE_CYCLES); ignored for TAP_RESET.
- cmd_data  input  DATA_W  TDI bits, shifted out LSB first.
- rsp_valid  output  1  command complete; held until accepted.
- rsp_ready  input  1  response consumed.
- rsp_data  output  DATA_W  captured TDO bits; bit i = i-th shift sample; unused bits 0.
- TCK  output  1  JTAG test clock.
- TMS  output  1  JTAG mode select.
- TDI  output  1  JTAG data to target.
- TDO  input  1  JTAG data from target.

Behaviour:
- Reset values: TCK=0, TMS=1, TDI=0, cmd_ready=1, rsp_valid=0, rsp_data=0.
- Reset is asynchronous. Asserting rst_n mid-command aborts it immediately; no response is issued.
- After reset the engine assumes the target is in Run-Test/Idle. The host issues TAP_RESET first.
- Tick counter runs 0..DIV-1 only while a command is active. At each wrap TCK toggles.
- TMS/TDI change only on TCK falling edges, or at command accept while TCK=0.
- TDO is sampled on TCK rising edges, only during Shift-xR edges.
- cmd_ready=1 only in state IDLE with rsp_valid=0.
- Accept occurs on cmd_valid & cmd_ready. The first TMS/TDI values are registered on the accept edge. The first TCK rise follows DIV clk cycles later.
- FSM states: IDLE, RESET5, SEL, CAPTURE, SHIFT, EXIT_UPD, DWELL, DONE.
- TAP_RESET: 6 TCK rises with TMS = 1,1,1,1,1,0; target ends in Run-Test/Idle.
- IDLE_CYCLES: cmd_len TCK rises with TMS=0.
- DR_SCAN, len L, L+5 rises: TMS = 1 (Select-DR), 0 (Capture), 0 (enter Shift).
  - Then L shift rises with TDI=cmd_data[i]; TMS=0, except TMS=1 on the last shift.
  - Then TMS = 1 (Update), 0 (Idle).
- IR_SCAN: identical to DR_SCAN with one extra leading TMS=1 (Select-IR); L+6 rises.
- After the final rise, the engine waits for the following falling edge (TCK=0), then enters DONE. rsp_valid asserts on the next clk.
- TAP_RESET and IDLE_CYCLES return rsp_data=0.
- Length 0 for IDLE_CYCLES or a scan: no TCK edges; rsp_valid asserts 1 cycle after accept; rsp_data=0.
- cmd_len > DATA_W saturates to DATA_W.
- Response backpressure: rsp_valid and rsp_data hold while rsp_ready=0; TCK stays 0; cmd_ready stays 0.
- The response transfers on rsp_valid & rsp_ready. cmd_ready returns 1 on the next cycle, giving one response per command.
- TDI returns to 0 after each scan. TMS holds its last value (0) between commands.

Optional Feature:
- Macro JTAG_TAP_MASTER_TRST_EN.
- When defined: adds output TRST_N (reset value 0, driven 1 after the first clk following reset release).
  - TAP_RESET also drives TRST_N=0 for the whole 6-rise sequence, returning to 1 with the final TMS=0 falling edge.
- When undefined: no TRST_N port; TAP reset is TMS-only.

Test Plan:
- DIV=3, TAP_RESET -> 6 TCK rises with period 6 clk; TMS samples 1,1,1,1,1,0; rsp_valid=1 with rsp_data=0.
- IR_SCAN len=4 data=0x2, TDO tied 1 -> 10 rises; TMS samples 1,1,0,0,0,0,0,1,1,0; TDI samples on shift rises 0,1,0,0; rsp_data=0xF.
- DR_SCAN len=3 data=0x5 into a bench TAP whose DR is a 1-bit register reset to 0 (TDO = previous TDI) -> rsp_data=0x2.
- DR_SCAN len=100 data all-ones -> saturates to 64 shift rises (69 total); rsp_data=all-ones with 1-bit model, bit0=0.
- rsp_ready held 0 for 10 cycles after completion -> rsp_valid and rsp_data stable; cmd_ready=0; TCK=0; next command accepted 1 cycle after handshake.
- rst_n pulsed low during the 20th shift of a 51-bit DR_SCAN -> TCK=0, TMS=1, TDI=0, rsp_valid=0 immediately; cmd_ready=1 after release.
